// File: rtl/conv_mac_engine.sv
// conv_mac_engine: multi-channel KxK convolution MAC engine.
// Each accepted beat carries one KxK window/weight pair for one input channel.
// CIN beats are accumulated on top of a per-output bias. The engine then emits
// the raw accumulator and a rounded, ReLU'd, saturated OUT_W-bit activation.
// That result is held under output backpressure.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   valid_in         beat valid; accepted when valid_in && in_ready
//   in_ready         combinational; low only when the completing beat would overwrite an unaccepted result
//   window_in        K*K signed pixels, element 0 in MSBs
//   weight_in        K*K signed weights, same packing
//   bias_in          signed bias, sampled on channel 0 beat
//   relu_en          ReLU enable, sampled on the last channel beat
//   flush            synchronous abort of the partial accumulation
//   valid_out        result valid, held until ready_out
//   ready_out        downstream ready
//   acc_out          bias + sum, pre-ReLU
//   q_out            requantised activation
//   ch_cnt           index of next expected channel beat
module conv_mac_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned CIN    = 4,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned SHIFT  = 0,
  localparam int unsigned CNT_W = (CIN > 1) ? $clog2(CIN) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      valid_in,
  output logic                      in_ready,
  input  logic [DATA_W*K*K-1:0]     window_in,
  input  logic [DATA_W*K*K-1:0]     weight_in,
  input  logic signed [ACC_W-1:0]   bias_in,
  input  logic                      relu_en,
  input  logic                      flush,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic signed [ACC_W-1:0]   acc_out,
  output logic signed [OUT_W-1:0]   q_out,
  output logic [CNT_W-1:0]          ch_cnt
);

  localparam int unsigned KK     = K * K;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CIN - 1);
  localparam logic [ACC_W:0]   ONE     = (ACC_W + 1)'(1);
  localparam logic [ACC_W:0]   RND     = (SHIFT > 0) ? (ONE << RND_SH) : '0;
  // Clamp bounds at ACC_W+1 bits; the minimum is the bitwise complement of the maximum.
  localparam logic [ACC_W:0]   QMAX    = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic [ACC_W:0]   QMIN    = ~QMAX;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  dot;
  logic signed [DATA_W-1:0] pix;
  logic signed [DATA_W-1:0] wt;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  relu_val;
  logic signed [ACC_W:0]    r_ext;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [OUT_W-1:0]  q_next;
  logic                     first_ch;
  logic                     last_ch;
  logic                     accept;

  assign first_ch = (ch_cnt == '0);
  assign last_ch  = (ch_cnt == LAST_CH);
  assign in_ready = !(last_ch && valid_out && !ready_out);
  assign accept   = valid_in && in_ready && !flush;

  // Dot product of the window; products are sign-extended and wrap at ACC_W.
  always_comb begin
    dot  = '0;
    pix  = '0;
    wt   = '0;
    prod = '0;
    for (int unsigned i = 0; i < KK; i++) begin
      pix  = window_in[DATA_W*(KK-1-i) +: DATA_W];
      wt   = weight_in[DATA_W*(KK-1-i) +: DATA_W];
      prod = pix * wt;
      dot  = dot + ACC_W'(prod);
    end
  end

  // Channel 0 restarts from the bias; later channels continue the running sum.
  always_comb begin
    base = first_ch ? bias_in : acc;
    sum  = base + dot;
  end

  // ReLU, round-half-up shift at ACC_W+1 bits, then saturate to OUT_W.
  always_comb begin
    relu_val = (relu_en && sum[ACC_W-1]) ? '0 : sum;
    r_ext    = {relu_val[ACC_W-1], relu_val};
    rounded  = r_ext + $signed(RND);
    shifted  = rounded >>> SHIFT;
    if (shifted > $signed(QMAX)) begin
      q_next = QMAX[OUT_W-1:0];
    end else if (shifted < $signed(QMIN)) begin
      q_next = QMIN[OUT_W-1:0];
    end else begin
      q_next = shifted[OUT_W-1:0];
    end
  end

  // Channel counter and partial accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_cnt <= '0;
      acc    <= '0;
    end else if (flush) begin
      ch_cnt <= '0;
      acc    <= '0;
    end else if (accept) begin
      ch_cnt <= last_ch ? '0 : ch_cnt + CNT_W'(1);
      if (!last_ch) begin
        acc <= sum;
      end
    end
  end

  // Output register; a completing beat reloads it even while the old result is being taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      acc_out   <= '0;
      q_out     <= '0;
    end else if (accept && last_ch) begin
      valid_out <= 1'b1;
      acc_out   <= sum;
      q_out     <= q_next;
    end else if (valid_out && ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine with K=3, CIN=4, SHIFT=4, OUT_W=8.
module tb_conv_mac_engine;

  logic               clk;
  logic               rstn;
  logic               valid_in;
  logic               in_ready;
  logic [71:0]        window_in;
  logic [71:0]        weight_in;
  logic signed [31:0] bias_in;
  logic               relu_en;
  logic               flush;
  logic               valid_out;
  logic               ready_out;
  logic signed [31:0] acc_out;
  logic signed [7:0]  q_out;
  logic [1:0]         ch_cnt;

  int checks   = 0;
  int failures = 0;

  conv_mac_engine #(
    .DATA_W(8), .ACC_W(32), .K(3), .CIN(4), .OUT_W(8), .SHIFT(4)
  ) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .in_ready(in_ready),
    .window_in(window_in), .weight_in(weight_in), .bias_in(bias_in),
    .relu_en(relu_en), .flush(flush), .valid_out(valid_out),
    .ready_out(ready_out), .acc_out(acc_out), .q_out(q_out), .ch_cnt(ch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat with every window element = p and every weight = w, for one clock.
  task automatic beat(input logic [7:0] p, input logic [7:0] w,
                      input logic signed [31:0] b, input logic r);
    valid_in  = 1'b1;
    window_in = {9{p}};
    weight_in = {9{w}};
    bias_in   = b;
    relu_en   = r;
    step();
  endtask

  task automatic group(input logic [7:0] p, input logic [7:0] w,
                       input logic signed [31:0] b, input logic r);
    for (int i = 0; i < 4; i++) beat(p, w, b, r);
    valid_in = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; valid_in = 1'b0; window_in = '0; weight_in = '0;
    bias_in = '0; relu_en = 1'b0; flush = 1'b0; ready_out = 1'b1;
    #12;
    chk("rst_valid_out", 64'(valid_out), 0);
    chk("rst_acc_out", 64'(acc_out), 0);
    chk("rst_q_out", 64'(q_out), 0);
    chk("rst_ch_cnt", 64'(ch_cnt), 0);
    rstn = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 1);

    // Test 1: basic group, 10 + 4*9*6 = 226, (226+8)>>4 = 14.
    group(8'd2, 8'd3, 32'sd10, 1'b0);
    chk("t1_valid_out", 64'(valid_out), 1);
    chk("t1_acc_out", 64'(acc_out), 226);
    chk("t1_q_out", 64'(q_out), 14);
    chk("t1_ch_cnt", 64'(ch_cnt), 0);
    step();
    chk("t1_valid_drop", 64'(valid_out), 0);

    // Test 2: negative saturation, then ReLU.
    group(8'h80, 8'd127, 32'sd0, 1'b0);
    chk("t2_acc_out", 64'(acc_out), -585216);
    chk("t2_q_out", 64'(q_out), -128);
    step();
    group(8'h80, 8'd127, 32'sd0, 1'b1);
    chk("t2r_acc_out", 64'(acc_out), -585216);
    chk("t2r_q_out", 64'(q_out), 0);
    step();

    // Test 3: positive saturation, hold, then one-cycle accept.
    group(8'd127, 8'd127, 32'sd0, 1'b0);
    chk("t3_acc_out", 64'(acc_out), 580644);
    chk("t3_q_out", 64'(q_out), 127);
    ready_out = 1'b0;
    step();
    chk("t3_hold_valid", 64'(valid_out), 1);
    chk("t3_hold_acc", 64'(acc_out), 580644);
    ready_out = 1'b1;
    step();
    chk("t3_valid_drop", 64'(valid_out), 0);

    // Test 4: backpressure; second group bias 26 -> 242, (242+8)>>4 = 15.
    group(8'd2, 8'd3, 32'sd10, 1'b0);
    chk("t4_first_valid", 64'(valid_out), 1);
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) beat(8'd2, 8'd3, 32'sd26, 1'b0);
    chk("t4_ch_cnt3", 64'(ch_cnt), 3);
    chk("t4_in_ready_low", 64'(in_ready), 0);
    step();
    chk("t4_stall_ch", 64'(ch_cnt), 3);
    chk("t4_stall_valid", 64'(valid_out), 1);
    chk("t4_stall_acc", 64'(acc_out), 226);
    chk("t4_stall_q", 64'(q_out), 14);
    ready_out = 1'b1;
    #1;
    chk("t4_in_ready_high", 64'(in_ready), 1);
    step();
    valid_in = 1'b0;
    chk("t4_b2b_valid", 64'(valid_out), 1);
    chk("t4_b2b_acc", 64'(acc_out), 242);
    chk("t4_b2b_q", 64'(q_out), 15);
    chk("t4_b2b_ch", 64'(ch_cnt), 0);
    step();
    chk("t4_valid_drop", 64'(valid_out), 0);

    // Test 5: flush drops the partial sum and the concurrent beat.
    beat(8'd2, 8'd3, 32'sd10, 1'b0);
    beat(8'd2, 8'd3, 32'sd10, 1'b0);
    chk("t5_pre_flush_ch", 64'(ch_cnt), 2);
    flush = 1'b1;
    beat(8'd2, 8'd3, 32'sd10, 1'b0);
    flush = 1'b0;
    chk("t5_flush_ch", 64'(ch_cnt), 0);
    chk("t5_flush_valid", 64'(valid_out), 0);
    group(8'd1, 8'd1, 32'sd0, 1'b0);
    chk("t5_acc_out", 64'(acc_out), 36);
    chk("t5_q_out", 64'(q_out), 2);
    step();

    // Test 6: asynchronous reset mid-group with a result pending.
    ready_out = 1'b0;
    group(8'd127, 8'd127, 32'sd0, 1'b0);
    beat(8'd2, 8'd3, 32'sd10, 1'b0);
    beat(8'd2, 8'd3, 32'sd10, 1'b0);
    valid_in = 1'b0;
    chk("t6_pre_valid", 64'(valid_out), 1);
    chk("t6_pre_ch", 64'(ch_cnt), 2);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(valid_out), 0);
    chk("t6_rst_acc", 64'(acc_out), 0);
    chk("t6_rst_q", 64'(q_out), 0);
    chk("t6_rst_ch", 64'(ch_cnt), 0);
    #10;
    rstn = 1'b1;
    ready_out = 1'b1;
    step();
    group(8'd2, 8'd3, 32'sd10, 1'b0);
    chk("t6_acc_out", 64'(acc_out), 226);
    chk("t6_q_out", 64'(q_out), 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
